// File: rtl/cae_iniciador_pkg.sv
// Slave map constants shared with cae and state encoding for the iniciador sequencer.
package cae_iniciador_pkg;

   localparam int unsigned BASE_FONTE     = 0;
   localparam int unsigned BASE_DESTINO   = 1;
   localparam int unsigned BASE_GMA       = 2;
   localparam int unsigned BASE_OBSTACULO = 1024;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_OBST      = 4'd1;
   localparam logic [3:0] ST_DEST      = 4'd2;
   localparam logic [3:0] ST_FONTE     = 4'd3;
   localparam logic [3:0] ST_POLL_WAIT = 4'd4;
   localparam logic [3:0] ST_POLL_RD   = 4'd5;
   localparam logic [3:0] ST_POLL_CHK  = 4'd6;
   localparam logic [3:0] ST_PATH_RD   = 4'd7;
   localparam logic [3:0] ST_PATH_CAP  = 4'd8;
   localparam logic [3:0] ST_PATH_OUT  = 4'd9;

   // States covered by the timeout budget.
   function automatic logic is_poll_phase(input logic [3:0] st);
      return (st == ST_POLL_WAIT) || (st == ST_POLL_RD) || (st == ST_POLL_CHK);
   endfunction

endpackage

// File: rtl/cae_poll_timer.sv
// Gap counter between pronto polls and the poll-phase timeout counter.
module cae_poll_timer
   import cae_iniciador_pkg::*;
#(
   parameter int unsigned POLL_GAP       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic gap_run,
   input  logic tmo_run,
   output logic gap_done,
   output logic tmo_expire
);

   localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [GW-1:0] gap_cnt_q;
   logic [TW-1:0] tmo_cnt_q;

   assign gap_done   = gap_run && (gap_cnt_q == GW'(POLL_GAP - 1));
   assign tmo_expire = tmo_run && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gap_cnt_q <= '0;
      end else if (!gap_run || gap_done) begin
         gap_cnt_q <= '0;
      end else begin
         gap_cnt_q <= gap_cnt_q + GW'(1);
      end
   end

   // Cleared the cycle before the fonte write is on the bus, so count 0 aligns with it.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         tmo_cnt_q <= '0;
      end else if (tmo_run && !tmo_expire) begin
         tmo_cnt_q <= tmo_cnt_q + TW'(1);
      end
   end

endmodule

// File: rtl/cae_iniciador.sv
// Avalon-MM master that loads obstacles, launches a cae path search, polls pronto and
// streams the resulting path words out on a ready/valid interface.
module cae_iniciador
   import cae_iniciador_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned AV_DATA_WIDTH  = 32,
   parameter int unsigned AV_ADDR_WIDTH  = 32,
   parameter int unsigned MAX_PATH       = 64,
   parameter int unsigned POLL_GAP       = 8,
   parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_in,
   input  logic [ADDR_WIDTH-1:0]    fonte_in,
   input  logic [ADDR_WIDTH-1:0]    destino_in,
   input  logic                     obst_valid_in,
   input  logic [ADDR_WIDTH-1:0]    obst_addr_in,
   input  logic                     obst_data_in,
   input  logic                     obst_last_in,
   output logic                     obst_ready_out,
   output logic [AV_ADDR_WIDTH-1:0] av_addr_out,
   output logic [AV_DATA_WIDTH-1:0] av_data_out,
   output logic                     av_write_out,
   output logic                     av_read_out,
   input  logic [AV_DATA_WIDTH-1:0] av_readdata_in,
   output logic                     res_valid_out,
   output logic [ADDR_WIDTH-1:0]    res_data_out,
   output logic                     res_last_out,
   input  logic                     res_ready_in,
   output logic                     busy_out,
   output logic                     timeout_out
);

   localparam int unsigned IW = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;

   logic [3:0]               state_q, state_d;
   logic [ADDR_WIDTH-1:0]    fonte_q, fonte_d;
   logic [ADDR_WIDTH-1:0]    destino_q, destino_d;
   logic [ADDR_WIDTH-1:0]    word_q, word_d;
   logic [IW-1:0]            idx_q, idx_d, idx_nxt;
   logic                     last_q, last_d;
   logic                     timeout_q, timeout_d;
   logic [AV_ADDR_WIDTH-1:0] av_addr_q, av_addr_d;
   logic [AV_DATA_WIDTH-1:0] av_data_q, av_data_d;
   logic                     av_write_q, av_write_d;
   logic                     av_read_q, av_read_d;
   logic                     gap_done, tmo_expire;
   logic [ADDR_WIDTH-1:0]    rd_word;
   logic                     unused_rd;

   assign rd_word   = av_readdata_in[ADDR_WIDTH-1:0];
   assign unused_rd = ^av_readdata_in[AV_DATA_WIDTH-1:ADDR_WIDTH];
   assign idx_nxt   = idx_q + IW'(1);

   cae_poll_timer #(
      .POLL_GAP       (POLL_GAP),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_poll_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (state_q == ST_FONTE),
      .gap_run    (state_q == ST_POLL_WAIT),
      .tmo_run    (is_poll_phase(state_q)),
      .gap_done   (gap_done),
      .tmo_expire (tmo_expire)
   );

   // Bus strobes are decided here and appear on the bus the following cycle.
   always_comb begin
      state_d    = state_q;
      fonte_d    = fonte_q;
      destino_d  = destino_q;
      word_d     = word_q;
      idx_d      = idx_q;
      last_d     = last_q;
      timeout_d  = timeout_q;
      av_addr_d  = '0;
      av_data_d  = '0;
      av_write_d = 1'b0;
      av_read_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               fonte_d   = fonte_in;
               destino_d = destino_in;
               timeout_d = 1'b0;
               state_d   = ST_OBST;
            end
         end
         ST_OBST: begin
            if (obst_valid_in) begin
               av_write_d = 1'b1;
               av_addr_d  = AV_ADDR_WIDTH'(BASE_OBSTACULO) + AV_ADDR_WIDTH'(obst_addr_in);
               av_data_d  = AV_DATA_WIDTH'(obst_data_in);
               if (obst_last_in) state_d = ST_DEST;
            end
         end
         ST_DEST: begin
            av_write_d = 1'b1;
            av_addr_d  = AV_ADDR_WIDTH'(BASE_DESTINO);
            av_data_d  = AV_DATA_WIDTH'(destino_q);
            state_d    = ST_FONTE;
         end
         ST_FONTE: begin
            av_write_d = 1'b1;
            av_addr_d  = AV_ADDR_WIDTH'(BASE_FONTE);
            av_data_d  = AV_DATA_WIDTH'(fonte_q);
            state_d    = ST_POLL_WAIT;
         end
         ST_POLL_WAIT: begin
            if (tmo_expire) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (gap_done) begin
               av_read_d = 1'b1;
               av_addr_d = AV_ADDR_WIDTH'(BASE_FONTE);
               state_d   = ST_POLL_RD;
            end
         end
         ST_POLL_RD: begin
            if (tmo_expire) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_POLL_CHK;
            end
         end
         ST_POLL_CHK: begin
            if (tmo_expire) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (av_readdata_in[0]) begin
               idx_d     = '0;
               av_read_d = 1'b1;
               av_addr_d = AV_ADDR_WIDTH'(BASE_GMA);
               state_d   = ST_PATH_RD;
            end else begin
               state_d = ST_POLL_WAIT;
            end
         end
         ST_PATH_RD: begin
            state_d = ST_PATH_CAP;
         end
         ST_PATH_CAP: begin
            word_d  = rd_word;
            last_d  = (rd_word == destino_q) || (idx_q == IW'(MAX_PATH - 1));
            state_d = ST_PATH_OUT;
         end
         ST_PATH_OUT: begin
            if (res_ready_in) begin
               if (last_q) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d     = idx_nxt;
                  av_read_d = 1'b1;
                  av_addr_d = AV_ADDR_WIDTH'(BASE_GMA) + AV_ADDR_WIDTH'(idx_nxt);
                  state_d   = ST_PATH_RD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fonte_q    <= '0;
         destino_q  <= '0;
         word_q     <= '0;
         idx_q      <= '0;
         last_q     <= 1'b0;
         timeout_q  <= 1'b0;
         av_addr_q  <= '0;
         av_data_q  <= '0;
         av_write_q <= 1'b0;
         av_read_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fonte_q    <= fonte_d;
         destino_q  <= destino_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         timeout_q  <= timeout_d;
         av_addr_q  <= av_addr_d;
         av_data_q  <= av_data_d;
         av_write_q <= av_write_d;
         av_read_q  <= av_read_d;
      end
   end

   assign obst_ready_out = (state_q == ST_OBST);
   assign busy_out       = (state_q != ST_IDLE);
   assign res_valid_out  = (state_q == ST_PATH_OUT);
   assign res_data_out   = res_valid_out ? word_q : '0;
   assign res_last_out   = res_valid_out && last_q;
   assign timeout_out    = timeout_q;
   assign av_addr_out    = av_addr_q;
   assign av_data_out    = av_data_q;
   assign av_write_out   = av_write_q;
   assign av_read_out    = av_read_q;

endmodule

// File: tb/tb_cae_iniciador.sv
// Directed bench for cae_iniciador with a small cae slave model (pronto + GMA window).
module tb_cae_iniciador;

   localparam int unsigned AW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_in = 1'b0;
   logic [AW-1:0] fonte_in = '0;
   logic [AW-1:0] destino_in = '0;
   logic          obst_valid_in = 1'b0;
   logic [AW-1:0] obst_addr_in = '0;
   logic          obst_data_in = 1'b0;
   logic          obst_last_in = 1'b0;
   logic          obst_ready_out;
   logic [31:0]   av_addr_out;
   logic [31:0]   av_data_out;
   logic          av_write_out;
   logic          av_read_out;
   logic [31:0]   av_readdata_in = '0;
   logic          res_valid_out;
   logic [AW-1:0] res_data_out;
   logic          res_last_out;
   logic          res_ready_in = 1'b0;
   logic          busy_out;
   logic          timeout_out;

   cae_iniciador #(
      .ADDR_WIDTH     (AW),
      .AV_DATA_WIDTH  (32),
      .AV_ADDR_WIDTH  (32),
      .MAX_PATH       (4),
      .POLL_GAP       (8),
      .TIMEOUT_CYCLES (200)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_in       (start_in),
      .fonte_in       (fonte_in),
      .destino_in     (destino_in),
      .obst_valid_in  (obst_valid_in),
      .obst_addr_in   (obst_addr_in),
      .obst_data_in   (obst_data_in),
      .obst_last_in   (obst_last_in),
      .obst_ready_out (obst_ready_out),
      .av_addr_out    (av_addr_out),
      .av_data_out    (av_data_out),
      .av_write_out   (av_write_out),
      .av_read_out    (av_read_out),
      .av_readdata_in (av_readdata_in),
      .res_valid_out  (res_valid_out),
      .res_data_out   (res_data_out),
      .res_last_out   (res_last_out),
      .res_ready_in   (res_ready_in),
      .busy_out       (busy_out),
      .timeout_out    (timeout_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int overlap  = 0;

   int wr_addr[$];
   int wr_data[$];
   int wr_cyc[$];
   int rd_addr[$];
   int rd_cyc[$];
   int fonte_cyc = 0;
   bit fonte_seen = 0;
   bit pronto_en = 0;
   int pronto_delay = 0;
   int path_mem[8];
   int ob_addr[$];
   int ob_data[$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Slave: read data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (av_read_out) begin
         if (av_addr_out == 0)
            av_readdata_in <= {31'd0, pronto_en && fonte_seen && (cyc >= fonte_cyc + pronto_delay)};
         else if (av_addr_out >= 2 && av_addr_out < 10)
            av_readdata_in <= 32'(path_mem[av_addr_out - 2]);
         else
            av_readdata_in <= '0;
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (av_write_out) begin
         wr_addr.push_back(int'(av_addr_out));
         wr_data.push_back(int'(av_data_out));
         wr_cyc.push_back(cyc);
         if (av_addr_out == 0) begin
            fonte_cyc  = cyc;
            fonte_seen = 1;
         end
      end
      if (av_read_out) begin
         rd_addr.push_back(int'(av_addr_out));
         rd_cyc.push_back(cyc);
      end
      if (av_write_out && av_read_out) overlap++;
   end

   task automatic reset_logs();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      rd_addr.delete(); rd_cyc.delete();
      fonte_seen = 0;
   endtask

   task automatic start_job(input logic [AW-1:0] f, input logic [AW-1:0] d);
      reset_logs();
      fonte_in   = f;
      destino_in = d;
      start_in   = 1'b1;
      @(negedge clk);
      start_in   = 1'b0;
   endtask

   task automatic send_obst();
      logic rdy;
      for (int i = 0; i < ob_addr.size(); i++) begin
         obst_valid_in = 1'b1;
         obst_addr_in  = AW'(ob_addr[i]);
         obst_data_in  = ob_data[i][0];
         obst_last_in  = (i == ob_addr.size() - 1);
         for (int k = 0; k < 50; k++) begin
            rdy = obst_ready_out;
            @(negedge clk);
            if (rdy) break;
         end
      end
      obst_valid_in = 1'b0;
      obst_last_in  = 1'b0;
   endtask

   task automatic wait_fonte();
      for (int k = 0; k < 100 && !fonte_seen; k++) @(negedge clk);
      check_val("fonte_write_seen", fonte_seen, 1);
   endtask

   task automatic get_word(input int stall, input int exp_w, input bit exp_l, input string tag);
      int n;
      res_ready_in = 1'b0;
      for (int k = 0; k < 300 && !res_valid_out; k++) @(negedge clk);
      check_val({tag, "_valid"}, res_valid_out, 1);
      check_val({tag, "_data"}, res_data_out, exp_w);
      check_val({tag, "_last"}, res_last_out, exp_l);
      n = rd_addr.size();
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check_val({tag, "_stall_data"}, res_data_out, exp_w);
         check_val({tag, "_stall_valid"}, res_valid_out, 1);
      end
      if (stall > 0) check_val({tag, "_stall_no_read"}, rd_addr.size(), n);
      res_ready_in = 1'b1;
      @(negedge clk);
      res_ready_in = 1'b0;
   endtask

   initial begin
      int exp_wa[5];
      int exp_wd[5];
      int paths[$];
      int polls[$];

      // Reset held for 3 cycles.
      repeat (3) @(negedge clk);
      check_val("rst_outputs", {obst_ready_out, av_write_out, av_read_out, res_valid_out,
                                res_last_out, busy_out, timeout_out}, 0);
      check_val("rst_av_addr", av_addr_out, 0);
      check_val("rst_av_data", av_data_out, 0);
      check_val("rst_res_data", res_data_out, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Job A: three obstacles, pronto after 40 cycles, path 3,7,11.
      path_mem = '{3, 7, 11, 0, 0, 0, 0, 0};
      pronto_en = 1; pronto_delay = 40;
      ob_addr = '{5, 9, 12};
      ob_data = '{1, 1, 0};
      start_job(16'd3, 16'd11);
      check_val("a_busy", busy_out, 1);
      send_obst();
      wait_fonte();
      get_word(0, 3, 1'b0, "a_w0");
      get_word(5, 7, 1'b0, "a_w1");
      get_word(0, 11, 1'b1, "a_w2");
      check_val("a_done_busy", busy_out, 0);
      check_val("a_done_valid", res_valid_out, 0);
      exp_wa = '{1029, 1033, 1036, 1, 0};
      exp_wd = '{1, 1, 0, 11, 3};
      check_val("a_write_count", wr_addr.size(), 5);
      for (int i = 0; i < 5 && i < wr_addr.size(); i++) begin
         check_val($sformatf("a_wr%0d_addr", i), wr_addr[i], exp_wa[i]);
         check_val($sformatf("a_wr%0d_data", i), wr_data[i], exp_wd[i]);
         if (i > 0) check_val($sformatf("a_wr%0d_consec", i), wr_cyc[i] - wr_cyc[i-1], 1);
      end
      for (int i = 0; i < rd_addr.size(); i++) begin
         if (rd_addr[i] == 0) polls.push_back(rd_cyc[i]);
         else paths.push_back(rd_addr[i]);
      end
      check_val("a_poll_count", polls.size(), 5);
      if (polls.size() >= 2) begin
         check_val("a_first_poll", polls[0] - fonte_cyc, 8);
         check_val("a_poll_period", polls[1] - polls[0], 10);
      end
      check_val("a_path_reads", paths.size(), 3);
      for (int i = 0; i < paths.size() && i < 3; i++)
         check_val($sformatf("a_path_addr%0d", i), paths[i], i + 2);

      // Job B: zero obstacles, pronto never set -> timeout 200 cycles after fonte write.
      pronto_en = 0;
      ob_addr = '{0};
      ob_data = '{0};
      start_job(16'd5, 16'd9);
      send_obst();
      wait_fonte();
      for (int k = 0; k < 400 && cyc < fonte_cyc + 199; k++) @(negedge clk);
      check_val("b_pre_timeout", timeout_out, 0);
      check_val("b_pre_busy", busy_out, 1);
      @(negedge clk);
      check_val("b_timeout", timeout_out, 1);
      check_val("b_timeout_busy", busy_out, 0);
      check_val("b_no_result", res_valid_out, 0);
      check_val("b_poll_count", rd_addr.size(), 20);
      check_val("b_write_count", wr_addr.size(), 3);
      if (wr_addr.size() == 3) begin
         check_val("b_wr0_addr", wr_addr[0], 1024);
         check_val("b_wr1_data", wr_data[1], 9);
         check_val("b_wr2_data", wr_data[2], 5);
      end

      // Job C: destino never returned, MAX_PATH=4 caps the job at four words.
      pronto_en = 1; pronto_delay = 0;
      path_mem = '{20, 21, 22, 23, 24, 0, 0, 0};
      ob_addr = '{7};
      ob_data = '{1};
      start_job(16'd1, 16'd50);
      check_val("c_timeout_cleared", timeout_out, 0);
      send_obst();
      wait_fonte();
      get_word(0, 20, 1'b0, "c_w0");
      get_word(0, 21, 1'b0, "c_w1");
      get_word(0, 22, 1'b0, "c_w2");
      get_word(0, 23, 1'b1, "c_w3");
      repeat (5) @(negedge clk);
      paths.delete();
      for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] != 0) paths.push_back(rd_addr[i]);
      check_val("c_path_reads", paths.size(), 4);
      for (int i = 0; i < paths.size() && i < 4; i++)
         check_val($sformatf("c_path_addr%0d", i), paths[i], i + 2);
      check_val("c_idle", busy_out, 0);

      // Job D: fonte == destino ends after one word; reset while it waits in PATH_OUT.
      path_mem = '{6, 9, 9, 9, 0, 0, 0, 0};
      ob_addr = '{0};
      ob_data = '{0};
      start_job(16'd6, 16'd6);
      send_obst();
      wait_fonte();
      for (int k = 0; k < 300 && !res_valid_out; k++) @(negedge clk);
      check_val("d_valid", res_valid_out, 1);
      check_val("d_data", res_data_out, 6);
      check_val("d_last", res_last_out, 1);
      rst_n = 1'b0;
      reset_logs();
      @(negedge clk);
      check_val("d_rst_valid", res_valid_out, 0);
      check_val("d_rst_busy", busy_out, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_val("d_rst_no_strobes", wr_addr.size() + rd_addr.size(), 0);

      check_val("no_strobe_overlap", overlap, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
